rx_descramble_ctrl: RTL and testbench



---
 rtl/rx_descramble_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_rx_descramble_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_descramble_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rx_descramble_ctrl
// Description : Sequences the rx descrambler over one frame (header + N data
//               blocks), generating per-word PN from a reseeded 32-bit LFSR.
//               Optional statistics counters: define RX_DESCR_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_descramble_ctrl #(
    parameter int HDR_WORDS = 16,
    parameter int BLK_WORDS = 93,
    parameter int MIN_GAP   = 0
) (
    input  logic        logic_clk_in,
    input  logic        logic_rst_in,
    input  logic        frame_start_in,
    input  logic [7:0]  block_num_in,
    input  logic [31:0] seed_in,
    input  logic        word_valid_in,
    input  logic [31:0] word_in,
    output logic        word_ready_out,
    output logic        data_pulse_out,
    output logic [31:0] data_out,
    output logic [31:0] pn_out,
    output logic        frame_busy_out,
    output logic        frame_done_out,
`ifdef RX_DESCR_STAT_EN
    output logic [15:0] frame_cnt_out,
    output logic [15:0] err_cnt_out,
`endif
    output logic        frame_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [6:0] C_HDR_LAST = 7'(HDR_WORDS - 1);
    localparam logic [6:0] C_BLK_LAST = 7'(BLK_WORDS - 1);
    localparam logic [7:0] C_GAP      = 8'(MIN_GAP);

    state_t      state_q, state_d;
    logic [6:0]  wcnt_q,  wcnt_d;
    logic [7:0]  blk_q,   blk_d;
    logic [7:0]  n_q,     n_d;
    logic [31:0] seed_q,  seed_d;
    logic [31:0] lfsr_q,  lfsr_d;
    logic [7:0]  gap_q,   gap_d;
    logic        pulse_q, pulse_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] pn_q,    pn_d;
    logic        err_q,   err_d;

    logic        w_ready;
    logic        w_accept;
    logic [31:0] w_blk_seed;
    logic [31:0] w_pn_cur;

    function automatic logic [31:0] lfsr_adv32(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 32; i++) begin
            v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        end
        return v;
    endfunction

    assign w_ready    = ((state_q == ST_HEADER) || (state_q == ST_DATA)) && (gap_q == 8'd0);
    assign w_accept   = word_valid_in & w_ready;
    assign w_blk_seed = seed_q ^ {24'd0, blk_q};
    // An all-zero reseed would lock the LFSR, so substitute 1.
    assign w_pn_cur   = (wcnt_q != 7'd0) ? lfsr_q :
                        (w_blk_seed == 32'd0) ? 32'h0000_0001 : w_blk_seed;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        blk_d   = blk_q;
        n_d     = n_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        gap_d   = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
        pulse_d = 1'b0;
        data_d  = data_q;
        pn_d    = pn_q;
        err_d   = 1'b0;

        if (w_accept) begin
            gap_d   = C_GAP;
            pulse_d = 1'b1;
            data_d  = word_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start_in) begin
                    state_d = ST_HEADER;
                    n_d     = block_num_in;
                    seed_d  = seed_in;
                    wcnt_d  = 7'd0;
                    blk_d   = 8'd0;
                    lfsr_d  = 32'd0;
                end
            end
            ST_HEADER: begin
                err_d = frame_start_in;
                if (w_accept) begin
                    pn_d = 32'd0;
                    if (wcnt_q == C_HDR_LAST) begin
                        wcnt_d  = 7'd0;
                        state_d = (n_q == 8'd0) ? ST_DONE : ST_DATA;
                    end else begin
                        wcnt_d = wcnt_q + 7'd1;
                    end
                end
            end
            ST_DATA: begin
                err_d = frame_start_in;
                if (w_accept) begin
                    pn_d   = w_pn_cur;
                    lfsr_d = lfsr_adv32(w_pn_cur);
                    if (wcnt_q == C_BLK_LAST) begin
                        wcnt_d = 7'd0;
                        if (blk_q == n_q - 8'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            blk_d = blk_q + 8'd1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 7'd1;
                    end
                end
            end
            ST_DONE: begin
                err_d   = frame_start_in;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 7'd0;
            blk_q   <= 8'd0;
            n_q     <= 8'd0;
            seed_q  <= 32'd0;
            lfsr_q  <= 32'd0;
            gap_q   <= 8'd0;
            pulse_q <= 1'b0;
            data_q  <= 32'd0;
            pn_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            blk_q   <= blk_d;
            n_q     <= n_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            data_q  <= data_d;
            pn_q    <= pn_d;
            err_q   <= err_d;
        end
    end

    assign word_ready_out = w_ready;
    assign data_pulse_out = pulse_q;
    assign data_out       = data_q;
    assign pn_out         = pn_q;
    assign frame_busy_out = (state_q == ST_HEADER) || (state_q == ST_DATA);
    // DONE is only ever entered on the last accept, so it lines up with that word's pulse.
    assign frame_done_out = (state_q == ST_DONE);
    assign frame_err_out  = err_q;

`ifdef RX_DESCR_STAT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if ((state_q == ST_DONE) && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_out = frame_cnt_q;
    assign err_cnt_out   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_descramble_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_descramble_ctrl
// Description : Directed self-checking bench; one DUT with MIN_GAP=0 and one
//               with MIN_GAP=2, selected per test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_descramble_ctrl;

    localparam int C_HDR = 16;
    localparam int C_BLK = 93;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        fs;
    logic [7:0]  nblk;
    logic [31:0] seed;
    logic        valid;
    logic [31:0] word;

    int n_vec  = 0;
    int n_miss = 0;

    logic        ready0, pulse0, busy0, done0, err0;
    logic [31:0] data0, pn0;
    logic        ready1, pulse1, busy1, done1, err1;
    logic [31:0] data1, pn1;
`ifdef RX_DESCR_STAT_EN
    logic [15:0] fcnt0, ecnt0, fcnt1, ecnt1;
`endif

    wire         w_fs0    = fs & ~sel;
    wire         w_fs1    = fs & sel;
    wire         w_v0     = valid & ~sel;
    wire         w_v1     = valid & sel;
    wire         w_ready  = sel ? ready1 : ready0;
    wire         w_pulse  = sel ? pulse1 : pulse0;
    wire         w_busy   = sel ? busy1  : busy0;
    wire         w_done   = sel ? done1  : done0;
    wire         w_err    = sel ? err1   : err0;
    wire  [31:0] w_data   = sel ? data1  : data0;
    wire  [31:0] w_pn     = sel ? pn1    : pn0;

    always #2.5 clk = ~clk;

    rx_descramble_ctrl #(.HDR_WORDS(C_HDR), .BLK_WORDS(C_BLK), .MIN_GAP(0)) u_dut (
        .logic_clk_in   (clk),
        .logic_rst_in   (rst),
        .frame_start_in (w_fs0),
        .block_num_in   (nblk),
        .seed_in        (seed),
        .word_valid_in  (w_v0),
        .word_in        (word),
        .word_ready_out (ready0),
        .data_pulse_out (pulse0),
        .data_out       (data0),
        .pn_out         (pn0),
        .frame_busy_out (busy0),
        .frame_done_out (done0),
`ifdef RX_DESCR_STAT_EN
        .frame_cnt_out  (fcnt0),
        .err_cnt_out    (ecnt0),
`endif
        .frame_err_out  (err0)
    );

    rx_descramble_ctrl #(.HDR_WORDS(C_HDR), .BLK_WORDS(C_BLK), .MIN_GAP(2)) u_dut_gap (
        .logic_clk_in   (clk),
        .logic_rst_in   (rst),
        .frame_start_in (w_fs1),
        .block_num_in   (nblk),
        .seed_in        (seed),
        .word_valid_in  (w_v1),
        .word_in        (word),
        .word_ready_out (ready1),
        .data_pulse_out (pulse1),
        .data_out       (data1),
        .pn_out         (pn1),
        .frame_busy_out (busy1),
        .frame_done_out (done1),
`ifdef RX_DESCR_STAT_EN
        .frame_cnt_out  (fcnt1),
        .err_cnt_out    (ecnt1),
`endif
        .frame_err_out  (err1)
    );

    function automatic logic [31:0] pn_step32(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < 32; k++) begin
            v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, w_ready}, 32'd0);
        chk({tag, "_pulse"}, {31'd0, w_pulse}, 32'd0);
        chk({tag, "_data"},  w_data,           32'd0);
        chk({tag, "_pn"},    w_pn,             32'd0);
        chk({tag, "_busy"},  {31'd0, w_busy},  32'd0);
        chk({tag, "_done"},  {31'd0, w_done},  32'd0);
        chk({tag, "_err"},   {31'd0, w_err},   32'd0);
    endtask

    // Runs one frame on the selected DUT, checking every cycle against a
    // cycle model of handshake, latency, PN sequence and done/err pulses.
    task automatic run_frame(input bit sel_gap, input logic [7:0] n, input logic [31:0] sd,
                             input bit rnd_valid, input int err_at, input int abort_at);
        int          total;
        int          gap;
        int          acc;
        int          pcnt;
        int          since;
        int          cyc;
        int          budget;
        int          dk;
        int          b;
        bit          acc_prev;
        bit          fs_prev;
        bit          fs_sent;
        bit          fin;
        bit          aborted;
        bit          exp_busy;
        bit          exp_ready;
        bit          accept;
        logic [31:0] ms;
        logic [31:0] exp_pn;
        logic [31:0] base;

        total    = C_HDR + C_BLK * int'(n);
        gap      = sel_gap ? 2 : 0;
        acc      = 0;
        pcnt     = 0;
        since    = 1000;
        cyc      = 0;
        budget   = total * 8 + 100;
        acc_prev = 1'b0;
        fs_prev  = 1'b0;
        fs_sent  = 1'b0;
        fin      = 1'b0;
        aborted  = 1'b0;
        ms       = 32'd0;
        base     = {n, 8'h5C, 16'h0000};

        sel   = sel_gap;
        nblk  = n;
        seed  = sd;
        valid = 1'b0;
        fs    = 1'b1;
        tick();
        fs    = 1'b0;
        nblk  = 8'hFF;
        seed  = 32'hFFFF_FFFF;

        while (!fin && cyc < budget) begin
            exp_busy  = (acc < total);
            exp_ready = exp_busy && (since > gap);
            chk("busy",  {31'd0, w_busy},  {31'd0, exp_busy});
            chk("ready", {31'd0, w_ready}, {31'd0, exp_ready});
            chk("pulse", {31'd0, w_pulse}, {31'd0, acc_prev});
            chk("err",   {31'd0, w_err},   {31'd0, fs_prev});
            if (acc_prev) begin
                if (pcnt < C_HDR) begin
                    exp_pn = 32'd0;
                end else begin
                    dk = pcnt - C_HDR;
                    b  = dk / C_BLK;
                    if (dk % C_BLK == 0) begin
                        ms = sd ^ {24'd0, 8'(b)};
                        if (ms == 32'd0) ms = 32'h0000_0001;
                    end else begin
                        ms = pn_step32(ms);
                    end
                    exp_pn = ms;
                end
                chk("data", w_data, base + 32'(pcnt));
                chk("pn",   w_pn,   exp_pn);
                chk("done", {31'd0, w_done}, {31'd0, (pcnt == total - 1)});
                pcnt++;
            end else begin
                chk("done_idle", {31'd0, w_done}, 32'd0);
                if (!exp_busy) fin = 1'b1;
            end

            if (!fin) begin
                if (abort_at >= 0 && acc == abort_at) begin
                    valid = 1'b1;
                    rst   = 1'b1;
                    tick();
                    rst   = 1'b0;
                    chk_all_zero("abort");
                    aborted = 1'b1;
                    fin     = 1'b1;
                end else begin
                    valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                    word  = base + 32'(acc);
                    fs    = (err_at >= 0 && acc == err_at && !fs_sent);
                    if (fs) fs_sent = 1'b1;
                    accept = valid && exp_ready;
                    tick();
                    acc_prev = accept;
                    fs_prev  = fs;
                    fs       = 1'b0;
                    if (accept) begin
                        acc++;
                        since = 1;
                    end else begin
                        since++;
                    end
                    cyc++;
                end
            end
        end
        valid = 1'b0;
        chk("frame_end", {31'd0, fin}, 32'd1);
        if (!aborted) chk("pulse_count", 32'(pcnt), 32'(total));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        sel   = 1'b0;
        fs    = 1'b0;
        nblk  = 8'd0;
        seed  = 32'd0;
        valid = 1'b0;
        word  = 32'd0;
        tick();
        tick();
        tick();
        chk_all_zero("rst0");
        sel = 1'b1;
        chk_all_zero("rst1");
        sel = 1'b0;

        // Start during reset must be dropped.
        fs    = 1'b1;
        nblk  = 8'd1;
        tick();
        rst   = 1'b0;
        fs    = 1'b0;
        chk("rst_start_busy", {31'd0, w_busy}, 32'd0);
        tick();
        chk("rst_start_busy2", {31'd0, w_busy}, 32'd0);
        chk("rst_start_err",   {31'd0, w_err},  32'd0);

        // Abort at data word 40 of block 0, then a clean frame.
        run_frame(1'b0, 8'd1, 32'hA5A5_0001, 1'b0, -1, C_HDR + 40);
        run_frame(1'b0, 8'd1, 32'hA5A5_0001, 1'b0, -1, -1);
        // Block 1 reseed is 1^1=0, so the guard value 1 appears.
        run_frame(1'b0, 8'd2, 32'h0000_0001, 1'b0, -1, -1);
        run_frame(1'b0, 8'd0, 32'hDEAD_BEEF, 1'b0, -1, -1);
        // Start request at header word 5 is rejected with an err pulse.
        run_frame(1'b0, 8'd1, 32'h1234_5678, 1'b0, 5, -1);
        run_frame(1'b1, 8'd1, 32'hA5A5_0001, 1'b0, -1, -1);
        run_frame(1'b1, 8'd2, 32'hC001_D00D, 1'b1, -1, -1);
        run_frame(1'b0, 8'd1, 32'h0F0F_F0F0, 1'b1, 3, -1);
        // Largest frame; block 254 reseed hits zero and uses the guard.
        run_frame(1'b0, 8'd255, 32'h0000_00FE, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
